rs_branch_ooo: RTL and testbench

Parametrised branch reservation station that buffers decoded branch/jump ops until both source operands are resolved, then issues the oldest ready entry to the branch execution unit. It sits between the decoder and the branch unit. It snoops `NUM_CDB` result broadcast channels, supports back-pressure from the execution unit, and is cleared by pipeline flush on mispredict.

---
 rtl/rs_branch_ooo.sv | 212 +++++++++++++++++++++
 tb/tb_rs_branch_ooo.sv | 355 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rs_branch_ooo.sv
// -----------------------------------------------------------------------------
// rs_branch_ooo
//   Branch reservation station. Buffers decoded branch/jump ops until both
//   source operands are resolved, snooping NUM_CDB result broadcast channels,
//   then issues the oldest ready entry into a single output register that
//   feeds the branch execution unit.
//
// Ports
//   clk, rst           : rising-edge clock, asynchronous active-low reset
//   flush              : synchronous clear of all entries and the output reg
//   alloc_*            : decoder allocation port (valid/ready + op fields)
//   cdb_valid/tag/data : flat broadcast buses, channel c at slice c
//   out_*              : issue port (valid/ready + issued op and operands)
//   count              : number of occupied entries
// -----------------------------------------------------------------------------
module rs_branch_ooo #(
  parameter int          DEPTH    = 4,
  parameter int          DATA_W   = 32,
  parameter int          ADDR_W   = 32,
  parameter int          TAG_W    = 4,
  parameter int unsigned TAG_FREE = 0,
  parameter int          OP_W     = 6,
  parameter int          NUM_CDB  = 2,
  localparam int         SEL_W    = $clog2(DEPTH)
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        flush,
  input  logic                        alloc_valid,
  output logic                        alloc_ready,
  input  logic [OP_W-1:0]             alloc_op,
  input  logic [ADDR_W-1:0]           alloc_pc,
  input  logic [DATA_W-1:0]           alloc_offset,
  input  logic [TAG_W-1:0]            alloc_tag1,
  input  logic [TAG_W-1:0]            alloc_tag2,
  input  logic [DATA_W-1:0]           alloc_data1,
  input  logic [DATA_W-1:0]           alloc_data2,
  input  logic [NUM_CDB-1:0]          cdb_valid,
  input  logic [NUM_CDB*TAG_W-1:0]    cdb_tag,
  input  logic [NUM_CDB*DATA_W-1:0]   cdb_data,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [OP_W-1:0]             out_op,
  output logic [ADDR_W-1:0]           out_pc,
  output logic [DATA_W-1:0]           out_offset,
  output logic [DATA_W-1:0]           out_src1,
  output logic [DATA_W-1:0]           out_src2,
  output logic [SEL_W:0]              count
);

  localparam logic [TAG_W-1:0] TAG_FREE_V = TAG_W'(TAG_FREE);

  // Entry state
  logic [DEPTH-1:0]  r_busy;
  logic [DEPTH-1:0]  r_age [DEPTH];   // r_age[row][col]: row is older than col
  logic [OP_W-1:0]   r_op    [DEPTH];
  logic [ADDR_W-1:0] r_pc    [DEPTH];
  logic [DATA_W-1:0] r_off   [DEPTH];
  logic [TAG_W-1:0]  r_tag1  [DEPTH];
  logic [TAG_W-1:0]  r_tag2  [DEPTH];
  logic [DATA_W-1:0] r_data1 [DEPTH];
  logic [DATA_W-1:0] r_data2 [DEPTH];

  // Output register
  logic              r_out_valid;
  logic [OP_W-1:0]   r_out_op;
  logic [ADDR_W-1:0] r_out_pc;
  logic [DATA_W-1:0] r_out_offset;
  logic [DATA_W-1:0] r_out_src1;
  logic [DATA_W-1:0] r_out_src2;

  // Effective (post same-cycle wakeup) operands per entry
  logic [TAG_W-1:0]  w_tag1  [DEPTH];
  logic [TAG_W-1:0]  w_tag2  [DEPTH];
  logic [DATA_W-1:0] w_data1 [DEPTH];
  logic [DATA_W-1:0] w_data2 [DEPTH];
  logic [DEPTH-1:0]  w_ready;
  logic [DEPTH-1:0]  w_oldest;
  logic [SEL_W-1:0]  w_sel;
  logic [SEL_W-1:0]  w_free;
  logic [SEL_W:0]    w_count;
  logic [TAG_W-1:0]  w_new_tag1, w_new_tag2;
  logic [DATA_W-1:0] w_new_data1, w_new_data2;
  logic              w_alloc;
  logic              w_issue;

  // Resolve one operand against the CDB. Channels are scanned from the top
  // down so the lowest matching channel is the last (winning) assignment.
  // A pending tag is never TAG_FREE, so a TAG_FREE broadcast cannot match.
  function automatic void snoop(input  logic [TAG_W-1:0]  tag_in,
                                input  logic [DATA_W-1:0] data_in,
                                output logic [TAG_W-1:0]  tag_out,
                                output logic [DATA_W-1:0] data_out);
    tag_out  = tag_in;
    data_out = data_in;
    if (tag_in != TAG_FREE_V) begin
      for (int c = NUM_CDB - 1; c >= 0; c--) begin
        if (cdb_valid[c] && (cdb_tag[c*TAG_W +: TAG_W] == tag_in)) begin
          tag_out  = TAG_FREE_V;
          data_out = cdb_data[c*DATA_W +: DATA_W];
        end
      end
    end
  endfunction

  always_comb begin
    // NOTE: every combinational output gets a default before any branch so
    // no path leaves it unassigned, which would otherwise infer a latch.
    w_ready  = '0;
    w_oldest = '0;
    w_sel    = '0;
    w_free   = '0;
    w_count  = '0;
    for (int i = 0; i < DEPTH; i++) begin
      snoop(r_tag1[i], r_data1[i], w_tag1[i], w_data1[i]);
      snoop(r_tag2[i], r_data2[i], w_tag2[i], w_data2[i]);
      w_ready[i] = r_busy[i] && (w_tag1[i] == TAG_FREE_V) && (w_tag2[i] == TAG_FREE_V);
    end
    // An entry is the oldest ready one if no other ready entry is older.
    for (int i = 0; i < DEPTH; i++) begin
      w_oldest[i] = w_ready[i];
      for (int j = 0; j < DEPTH; j++) begin
        if (w_ready[j] && r_age[j][i]) w_oldest[i] = 1'b0;
      end
    end
    // Descending scan: the lowest free index is the final assignment.
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (w_oldest[i]) w_sel  = SEL_W'(i);
      if (!r_busy[i])  w_free = SEL_W'(i);
      w_count = w_count + (SEL_W + 1)'(r_busy[i]);
    end
    snoop(alloc_tag1, alloc_data1, w_new_tag1, w_new_data1);
    snoop(alloc_tag2, alloc_data2, w_new_tag2, w_new_data2);
  end

  assign alloc_ready = ~&r_busy;
  assign w_alloc     = alloc_valid && alloc_ready && !flush;
  assign w_issue     = (|w_ready) && (!r_out_valid || out_ready) && !flush;
  assign count       = w_count;

  // Control state: busy bits, age matrix and the output register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_busy       <= '0;
      r_out_valid  <= 1'b0;
      r_out_op     <= '0;
      r_out_pc     <= '0;
      r_out_offset <= '0;
      r_out_src1   <= '0;
      r_out_src2   <= '0;
      for (int i = 0; i < DEPTH; i++) r_age[i] <= '0;
    end else if (flush) begin
      // Output data fields are left as they are; only the valid drops.
      r_busy      <= '0;
      r_out_valid <= 1'b0;
      for (int i = 0; i < DEPTH; i++) r_age[i] <= '0;
    end else begin
      // NOTE: non-blocking assignments make every read in this block see the
      // pre-edge state, so issue and allocation in one cycle cannot interfere.
      if (w_issue) begin
        r_busy[w_sel] <= 1'b0;
        r_out_valid   <= 1'b1;
        r_out_op      <= r_op[w_sel];
        r_out_pc      <= r_pc[w_sel];
        r_out_offset  <= r_off[w_sel];
        r_out_src1    <= w_data1[w_sel];
        r_out_src2    <= w_data2[w_sel];
      end else if (out_ready) begin
        r_out_valid <= 1'b0;
      end
      // The new entry is younger than every currently busy entry. The row
      // and column of the target are fully rewritten, so stale bits left by
      // a previous occupant never survive.
      if (w_alloc) begin
        r_busy[w_free] <= 1'b1;
        for (int j = 0; j < DEPTH; j++) begin
          r_age[w_free][j] <= 1'b0;
          r_age[j][w_free] <= r_busy[j];
        end
      end
    end
  end

  // NOTE: the payload array has no reset; every read of it is qualified by a
  // busy bit, and leaving it unreset keeps it a plain register file.
  always_ff @(posedge clk) begin
    for (int i = 0; i < DEPTH; i++) begin
      if (w_alloc && (w_free == SEL_W'(i))) begin
        r_op[i]    <= alloc_op;
        r_pc[i]    <= alloc_pc;
        r_off[i]   <= alloc_offset;
        r_tag1[i]  <= w_new_tag1;
        r_data1[i] <= w_new_data1;
        r_tag2[i]  <= w_new_tag2;
        r_data2[i] <= w_new_data2;
      end else if (r_busy[i]) begin
        r_tag1[i]  <= w_tag1[i];
        r_data1[i] <= w_data1[i];
        r_tag2[i]  <= w_tag2[i];
        r_data2[i] <= w_data2[i];
      end
    end
  end

  assign out_valid  = r_out_valid;
  assign out_op     = r_out_op;
  assign out_pc     = r_out_pc;
  assign out_offset = r_out_offset;
  assign out_src1   = r_out_src1;
  assign out_src2   = r_out_src2;

endmodule

// File: tb/tb_rs_branch_ooo.sv
// -----------------------------------------------------------------------------
// tb_rs_branch_ooo
//   Self-checking bench for rs_branch_ooo. A queue-based reference model (the
//   queue order is the age order) is stepped on every clock edge and compared
//   with the DUT on every falling edge; directed scenarios add literal checks.
// -----------------------------------------------------------------------------
module tb_rs_branch_ooo;

  localparam int DEPTH   = 4;
  localparam int DATA_W  = 32;
  localparam int ADDR_W  = 32;
  localparam int TAG_W   = 4;
  localparam int OP_W    = 6;
  localparam int NUM_CDB = 2;
  localparam int SEL_W   = $clog2(DEPTH);

  logic                      clk;
  logic                      rst;
  logic                      flush;
  logic                      alloc_valid;
  logic                      alloc_ready;
  logic [OP_W-1:0]           alloc_op;
  logic [ADDR_W-1:0]         alloc_pc;
  logic [DATA_W-1:0]         alloc_offset;
  logic [TAG_W-1:0]          alloc_tag1, alloc_tag2;
  logic [DATA_W-1:0]         alloc_data1, alloc_data2;
  logic [NUM_CDB-1:0]        cdb_valid;
  logic [NUM_CDB*TAG_W-1:0]  cdb_tag;
  logic [NUM_CDB*DATA_W-1:0] cdb_data;
  logic                      out_valid;
  logic                      out_ready;
  logic [OP_W-1:0]           out_op;
  logic [ADDR_W-1:0]         out_pc;
  logic [DATA_W-1:0]         out_offset, out_src1, out_src2;
  logic [SEL_W:0]            count;

  rs_branch_ooo #(
    .DEPTH(DEPTH), .DATA_W(DATA_W), .ADDR_W(ADDR_W), .TAG_W(TAG_W),
    .TAG_FREE(0), .OP_W(OP_W), .NUM_CDB(NUM_CDB)
  ) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .alloc_valid(alloc_valid), .alloc_ready(alloc_ready),
    .alloc_op(alloc_op), .alloc_pc(alloc_pc), .alloc_offset(alloc_offset),
    .alloc_tag1(alloc_tag1), .alloc_tag2(alloc_tag2),
    .alloc_data1(alloc_data1), .alloc_data2(alloc_data2),
    .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_data(cdb_data),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_op(out_op), .out_pc(out_pc), .out_offset(out_offset),
    .out_src1(out_src1), .out_src2(out_src2), .count(count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Reference model: pending ops in a queue, oldest at the front.
  // ---------------------------------------------------------------------------
  typedef struct {
    logic [OP_W-1:0]   op;
    logic [ADDR_W-1:0] pc;
    logic [DATA_W-1:0] off;
    logic [TAG_W-1:0]  t1, t2;
    logic [DATA_W-1:0] d1, d2;
  } ent_t;

  ent_t q[$];
  ent_t m_out;
  logic m_ov = 1'b0;

  // Operand value as seen this cycle: first valid channel carrying the tag.
  function automatic void resolve(input logic [TAG_W-1:0] t, input logic [DATA_W-1:0] d,
                                  output logic [TAG_W-1:0] t_o, output logic [DATA_W-1:0] d_o);
    bit found = 0;
    t_o = t;
    d_o = d;
    if (t != 0) begin
      for (int c = 0; c < NUM_CDB; c++) begin
        if (!found && cdb_valid[c] && cdb_tag[c*TAG_W +: TAG_W] == t) begin
          found = 1;
          t_o   = 0;
          d_o   = cdb_data[c*DATA_W +: DATA_W];
        end
      end
    end
  endfunction

  task automatic model_step();
    int   prior = q.size();
    int   pick  = -1;
    ent_t e;
    logic [TAG_W-1:0]  t;
    logic [DATA_W-1:0] d;
    for (int i = 0; i < q.size(); i++) begin
      resolve(q[i].t1, q[i].d1, t, d); q[i].t1 = t; q[i].d1 = d;
      resolve(q[i].t2, q[i].d2, t, d); q[i].t2 = t; q[i].d2 = d;
    end
    if (!m_ov || out_ready) begin
      for (int i = 0; i < q.size(); i++)
        if (pick < 0 && q[i].t1 == 0 && q[i].t2 == 0) pick = i;
      if (pick >= 0) begin
        m_out = q[pick];
        m_ov  = 1'b1;
        q.delete(pick);
      end else begin
        m_ov = 1'b0;
      end
    end
    if (alloc_valid && prior < DEPTH) begin
      e.op  = alloc_op;
      e.pc  = alloc_pc;
      e.off = alloc_offset;
      resolve(alloc_tag1, alloc_data1, e.t1, e.d1);
      resolve(alloc_tag2, alloc_data2, e.t2, e.d2);
      q.push_back(e);
    end
  endtask

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      q.delete();
      m_ov = 1'b0;
    end else if (flush) begin
      q.delete();
      m_ov = 1'b0;
    end else begin
      model_step();
    end
  end

  // Compare process: outputs are settled at the falling edge.
  always @(negedge clk) begin
    if (rst) begin
      check("count", 64'(count), 64'(q.size()));
      check("alloc_ready", 64'(alloc_ready), 64'(q.size() < DEPTH));
      check("out_valid", 64'(out_valid), 64'(m_ov));
      if (m_ov) begin
        check("out_op", 64'(out_op), 64'(m_out.op));
        check("out_pc", 64'(out_pc), 64'(m_out.pc));
        check("out_offset", 64'(out_offset), 64'(m_out.off));
        check("out_src1", 64'(out_src1), 64'(m_out.d1));
        check("out_src2", 64'(out_src2), 64'(m_out.d2));
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Stimulus helpers
  // ---------------------------------------------------------------------------
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic idle();
    alloc_valid = 1'b0;
    cdb_valid   = '0;
    cdb_tag     = '0;
    cdb_data    = '0;
    flush       = 1'b0;
  endtask

  task automatic alloc_set(input logic [OP_W-1:0] op, input logic [ADDR_W-1:0] pc,
                           input logic [DATA_W-1:0] off,
                           input logic [TAG_W-1:0] t1, input logic [DATA_W-1:0] d1,
                           input logic [TAG_W-1:0] t2, input logic [DATA_W-1:0] d2);
    alloc_valid  = 1'b1;
    alloc_op     = op;
    alloc_pc     = pc;
    alloc_offset = off;
    alloc_tag1   = t1;
    alloc_data1  = d1;
    alloc_tag2   = t2;
    alloc_data2  = d2;
  endtask

  task automatic cdb_set(input int ch, input logic [TAG_W-1:0] t, input logic [DATA_W-1:0] d);
    cdb_valid[ch]                 = 1'b1;
    cdb_tag[ch*TAG_W +: TAG_W]    = t;
    cdb_data[ch*DATA_W +: DATA_W] = d;
  endtask

  initial begin
    rst = 1'b1;
    out_ready = 1'b1;
    alloc_op = '0; alloc_pc = '0; alloc_offset = '0;
    alloc_tag1 = '0; alloc_tag2 = '0; alloc_data1 = '0; alloc_data2 = '0;
    idle();
    #1 rst = 1'b0;
    repeat (2) @(posedge clk);
    #2;
    check("rst_count", 64'(count), 0);
    check("rst_out_valid", 64'(out_valid), 0);
    check("rst_alloc_ready", 64'(alloc_ready), 1);
    check("rst_out_op", 64'(out_op), 0);
    check("rst_out_pc", 64'(out_pc), 0);
    check("rst_out_offset", 64'(out_offset), 0);
    check("rst_out_src1", 64'(out_src1), 0);
    check("rst_out_src2", 64'(out_src2), 0);
    rst = 1'b1;
    tick();

    // Basic: free operands issue one edge after allocation.
    alloc_set(6'h18, 32'h100, 32'd8, 0, 32'd5, 0, 32'd5);
    tick(); idle();
    check("basic_count_alloc", 64'(count), 1);
    check("basic_not_same_cycle", 64'(out_valid), 0);
    tick();
    check("basic_valid", 64'(out_valid), 1);
    check("basic_src1", 64'(out_src1), 5);
    check("basic_src2", 64'(out_src2), 5);
    check("basic_pc", 64'(out_pc), 64'h100);
    check("basic_op", 64'(out_op), 64'h18);
    check("basic_offset", 64'(out_offset), 8);
    check("basic_count_after", 64'(count), 0);
    tick();
    check("basic_empty", 64'(out_valid), 0);

    // Wakeup with forwarding at the broadcast edge.
    alloc_set(6'h19, 32'h110, 32'd4, 3, 32'hDEAD, 0, 32'd7);
    tick(); idle();
    check("wake_waiting", 64'(out_valid), 0);
    cdb_set(1, 3, 32'hABCD);
    tick(); idle();
    check("wake_valid", 64'(out_valid), 1);
    check("wake_src1", 64'(out_src1), 64'hABCD);
    check("wake_src2", 64'(out_src2), 7);

    // Capture in the allocation cycle; both channels match, channel 0 wins.
    alloc_set(6'h1A, 32'h120, 32'd0, 3, 32'd0, 0, 32'd9);
    cdb_set(0, 3, 32'h1234);
    cdb_set(1, 3, 32'h5678);
    tick(); idle();
    check("cap_count", 64'(count), 1);
    check("cap_not_same_cycle", 64'(out_valid), 0);
    tick();
    check("cap_valid", 64'(out_valid), 1);
    check("cap_src1", 64'(out_src1), 64'h1234);

    // Age order: A waits on tag 2, B and C free.
    alloc_set(6'h1B, 32'h300, 32'd0, 2, 32'd0, 0, 32'd1);
    tick();
    alloc_set(6'h1B, 32'h304, 32'd0, 0, 32'd2, 0, 32'd2);
    tick();
    alloc_set(6'h1B, 32'h308, 32'd0, 0, 32'd3, 0, 32'd3);
    tick(); idle();
    check("age_first_b", 64'(out_pc), 64'h304);
    cdb_set(0, 2, 32'h55);
    tick(); idle();
    check("age_then_a", 64'(out_pc), 64'h300);
    check("age_a_src1", 64'(out_src1), 64'h55);
    tick();
    check("age_then_c", 64'(out_pc), 64'h308);
    tick();
    check("age_done", 64'(out_valid), 0);

    // Back-pressure and full: DEPTH+1 allocations of waiting ops.
    out_ready = 1'b0;
    for (int k = 0; k <= DEPTH; k++) begin
      alloc_set(6'h1C, 32'h200 + 32'(4*k), 32'(k), 5, 32'd0, 0, 32'(k));
      tick();
      if (k == DEPTH - 1) check("full_alloc_ready", 64'(alloc_ready), 0);
    end
    idle();
    check("full_count", 64'(count), DEPTH);
    cdb_set(0, 5, 32'h77);
    tick(); idle();
    check("bp_first", 64'(out_pc), 64'h200);
    check("bp_count", 64'(count), DEPTH - 1);
    tick(); tick();
    check("bp_hold_valid", 64'(out_valid), 1);
    check("bp_hold_pc", 64'(out_pc), 64'h200);
    check("bp_hold_src1", 64'(out_src1), 64'h77);
    out_ready = 1'b1;
    for (int k = 1; k < DEPTH; k++) begin
      tick();
      check("drain_pc", 64'(out_pc), 64'h200 + 64'(4*k));
    end
    tick();
    check("drain_empty", 64'(out_valid), 0);
    check("drain_count", 64'(count), 0);

    // Flush with 3 busy entries and a held output.
    out_ready = 1'b0;
    for (int k = 0; k < 4; k++) begin
      alloc_set(6'h1D, 32'h400 + 32'(4*k), 32'd0, 5, 32'd0, 0, 32'd0);
      tick();
    end
    idle();
    cdb_set(1, 5, 32'h99);
    tick(); idle();
    check("pre_flush_count", 64'(count), 3);
    check("pre_flush_valid", 64'(out_valid), 1);
    flush = 1'b1;
    alloc_set(6'h1E, 32'h500, 32'd0, 0, 32'd0, 0, 32'd0);
    tick(); idle();
    check("flush_count", 64'(count), 0);
    check("flush_valid", 64'(out_valid), 0);
    tick();
    check("flush_dropped", 64'(count), 0);

    // Asynchronous reset between edges.
    alloc_set(6'h1F, 32'h600, 32'd0, 0, 32'd0, 0, 32'd0);
    tick();
    alloc_set(6'h1F, 32'h604, 32'd0, 0, 32'd0, 0, 32'd0);
    tick(); idle();
    check("pre_rst_valid", 64'(out_valid), 1);
    check("pre_rst_count", 64'(count), 1);
    rst = 1'b0;
    #1;
    check("async_rst_valid", 64'(out_valid), 0);
    check("async_rst_count", 64'(count), 0);
    tick();
    rst = 1'b1;
    out_ready = 1'b1;
    tick();

    // Randomized traffic, checked every cycle by the compare process.
    for (int n = 0; n < 3000; n++) begin
      alloc_valid  = ($urandom_range(0, 99) < 55);
      alloc_op     = OP_W'($urandom);
      alloc_pc     = $urandom;
      alloc_offset = $urandom;
      alloc_tag1   = ($urandom_range(0, 1) == 1) ? '0 : TAG_W'($urandom_range(1, 5));
      alloc_tag2   = ($urandom_range(0, 2) != 0) ? '0 : TAG_W'($urandom_range(1, 5));
      alloc_data1  = $urandom;
      alloc_data2  = $urandom;
      for (int c = 0; c < NUM_CDB; c++) begin
        cdb_valid[c]                 = ($urandom_range(0, 99) < 40);
        cdb_tag[c*TAG_W +: TAG_W]    = TAG_W'($urandom_range(0, 5));
        cdb_data[c*DATA_W +: DATA_W] = $urandom;
      end
      flush     = ($urandom_range(0, 99) < 2);
      out_ready = ($urandom_range(0, 99) < 70);
      tick();
    end
    idle();
    out_ready = 1'b1;
    repeat (10) tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
